inst_fetch: RTL and testbench

//  Instruction-fetch (IF) stage; sits directly upstream of the ID decoder.

---
 rtl/inst_fetch.sv | 157 +++++++++++++++
 tb/tb_inst_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch : instruction-fetch stage feeding the ID decoder.
//
// Owns the PC and issues word reads to InstMem. The returned instruction and
// its PC are registered toward ID. A single-entry skid buffer absorbs the one
// word that can arrive while ID is stalled. Fetches on the wrong path are
// squashed when a jump/branch redirect arrives.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous, active-high reset
//   romCe      out  1            InstMem request, held until romRdy
//   romAddr    out  ADDR_LENGTH  InstMem word address (bits[1:0] = 0)
//   romRdy     in   1            romData valid this cycle (ignored if !romCe)
//   romData    in   INST_LENGTH  instruction from InstMem
//   stall      in   1            ID cannot accept a new instruction
//   jmpEn      in   1            redirect pulse
//   jmpAddr    in   ADDR_LENGTH  redirect target (bits[1:0] ignored)
//   inst       out  INST_LENGTH  instruction to ID, 0 when not valid
//   instPc     out  ADDR_LENGTH  PC of inst
//   instValid  out  1            inst/instPc hold a live instruction
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                       INST_LENGTH = 32,
  parameter int                       ADDR_LENGTH = 32,
  parameter logic [ADDR_LENGTH-1:0]   RESET_PC    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    romCe,
  output logic [ADDR_LENGTH-1:0]  romAddr,
  input  logic                    romRdy,
  input  logic [INST_LENGTH-1:0]  romData,
  input  logic                    stall,
  input  logic                    jmpEn,
  input  logic [ADDR_LENGTH-1:0]  jmpAddr,
  output logic [INST_LENGTH-1:0]  inst,
  output logic [ADDR_LENGTH-1:0]  instPc,
  output logic                    instValid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [ADDR_LENGTH-1:0] ALIGN_MASK = ~ADDR_LENGTH'(3);
  localparam logic [ADDR_LENGTH-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

  logic [1:0]             r_state;
  logic [ADDR_LENGTH-1:0] r_pc;
  logic [ADDR_LENGTH-1:0] r_sq_addr;
  logic                   r_skid_vld;
  logic [INST_LENGTH-1:0] r_skid_inst;
  logic [ADDR_LENGTH-1:0] r_skid_pc;
  logic                   r_inst_vld;
  logic [INST_LENGTH-1:0] r_inst;
  logic [ADDR_LENGTH-1:0] r_inst_pc;

  logic [ADDR_LENGTH-1:0] w_jmp_tgt;
  logic                   w_accept;
  logic                   w_out_free;

  assign w_jmp_tgt  = jmpAddr & ALIGN_MASK;
  // Only a FETCH-state response without a same-cycle redirect is a real
  // instruction; SQUASH responses and anything outside a request are dropped.
  assign w_accept   = (r_state == S_FETCH) && romRdy && !jmpEn;
  assign w_out_free = !r_inst_vld || !stall;

  assign romCe   = (r_state == S_FETCH) || (r_state == S_SQUASH);
  // The abandoned request must keep its address until memory answers it.
  assign romAddr = (r_state == S_SQUASH) ? r_sq_addr : r_pc;

  assign inst      = r_inst;
  assign instPc    = r_inst_pc;
  assign instValid = r_inst_vld;

  // Control: FSM, PC, skid occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_INIT;
      r_sq_addr  <= PC_INIT;
      r_skid_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          if (jmpEn) r_pc <= w_jmp_tgt;
        end
        S_FETCH: begin
          if (jmpEn) begin
            r_pc <= w_jmp_tgt;
            if (!romRdy) begin
              r_sq_addr <= r_pc;
              r_state   <= S_SQUASH;
            end
          end else if (romRdy) begin
            r_pc <= r_pc + ADDR_LENGTH'(4);
            if (!w_out_free) begin
              r_skid_vld <= 1'b1;
              r_state    <= S_HOLD;
            end
          end
        end
        S_SQUASH: begin
          if (jmpEn)  r_pc    <= w_jmp_tgt;
          if (romRdy) r_state <= S_FETCH;
        end
        default: begin // S_HOLD
          if (jmpEn) begin
            r_pc       <= w_jmp_tgt;
            r_skid_vld <= 1'b0;
            r_state    <= S_FETCH;
          end else if (!stall) begin
            r_skid_vld <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
      endcase
    end
  end

  // Skid payload: captured when a word arrives while ID is stalled
  always_ff @(posedge clk) begin
    if (w_accept && !w_out_free) begin
      r_skid_inst <= romData;
      r_skid_pc   <= r_pc;
    end
  end

  // Output register toward ID
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_vld <= 1'b0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
    end else if (jmpEn) begin
      r_inst_vld <= 1'b0;
      r_inst     <= '0;
    end else if (stall && r_inst_vld) begin
      r_inst_vld <= r_inst_vld;
    end else if (r_skid_vld) begin
      r_inst_vld <= 1'b1;
      r_inst     <= r_skid_inst;
      r_inst_pc  <= r_skid_pc;
    end else if (w_accept) begin
      r_inst_vld <= 1'b1;
      r_inst     <= romData;
      r_inst_pc  <= r_pc;
    end else begin
      r_inst_vld <= 1'b0;
      r_inst     <= '0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        romCe;
  logic [31:0] romAddr;
  logic        romRdy;
  logic [31:0] romData;
  logic        stall;
  logic        jmpEn;
  logic [31:0] jmpAddr;
  logic [31:0] inst;
  logic [31:0] instPc;
  logic        instValid;

  // Memory model: latency lat means romRdy on the (lat+1)-th romCe cycle.
  logic [3:0]  lat;
  logic [3:0]  cnt = '0;
  logic        m_rdy;
  logic        frc;
  logic        f_rdy;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] XK = 32'hA5A5_0000;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .romCe(romCe), .romAddr(romAddr), .romRdy(romRdy),
    .romData(romData), .stall(stall), .jmpEn(jmpEn), .jmpAddr(jmpAddr),
    .inst(inst), .instPc(instPc), .instValid(instValid)
  );

  always_comb begin
    m_rdy   = romCe && (cnt >= lat);
    romRdy  = frc ? f_rdy : m_rdy;
    romData = romAddr ^ XK;
  end

  always @(posedge clk) begin
    if (!romCe || m_rdy) cnt <= '0;
    else                 cnt <= cnt + 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cmp=%0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".romCe"},     {31'd0, romCe},     32'd0);
    chk({tag, ".romAddr"},   romAddr,            32'd0);
    chk({tag, ".instValid"}, {31'd0, instValid}, 32'd0);
    chk({tag, ".inst"},      inst,               32'd0);
    chk({tag, ".instPc"},    instPc,             32'd0);
  endtask

  // Wait (bounded) for the next valid instruction and check its PC/data.
  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    bit seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (instValid) seen = 1;
    end
    chk({tag, ".seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({tag, ".instPc"}, instPc, exp_pc);
      chk({tag, ".inst"},   inst,   exp_pc ^ XK);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        jmp;
    logic [31:0] jaddr;
    logic        ce;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[21];

  initial begin
    // zero-wait stream, stall/skid, jumps with and without stall
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'hC};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'hC};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'hC};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'hC};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'hC};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h10};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h14};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h203, 1'b1, 32'h200, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h304, 1'b1, 32'h300};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h308, 1'b1, 32'h300};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h404, 1'b1, 32'h400};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};

    rst = 1'b1; stall = 1'b0; jmpEn = 1'b0; jmpAddr = '0;
    lat = 4'd0; frc = 1'b1; f_rdy = 1'b0;

    // T1: reset held with random activity on the inputs
    for (int i = 0; i < 3; i++) begin
      f_rdy   = 1'($urandom_range(0, 1));
      stall   = 1'($urandom_range(0, 1));
      jmpEn   = 1'($urandom_range(0, 1));
      jmpAddr = $urandom;
      step();
      chk_reset($sformatf("t1_rst%0d", i));
    end
    frc = 1'b0; stall = 1'b0; jmpEn = 1'b0; jmpAddr = '0;

    // T2/T3/T5: table-driven cycle-by-cycle vectors, zero-wait memory
    for (int i = 0; i < 21; i++) begin
      rst     = tbl[i].rst;
      stall   = tbl[i].stall;
      jmpEn   = tbl[i].jmp;
      jmpAddr = tbl[i].jaddr;
      step();
      chk($sformatf("v%0d.romCe", i),     {31'd0, romCe},     {31'd0, tbl[i].ce});
      chk($sformatf("v%0d.romAddr", i),   romAddr,            tbl[i].addr);
      chk($sformatf("v%0d.instValid", i), {31'd0, instValid}, {31'd0, tbl[i].vld});
      chk($sformatf("v%0d.inst", i),      inst,               tbl[i].vld ? (tbl[i].pc ^ XK) : 32'h0);
      if (tbl[i].vld || tbl[i].rst)
        chk($sformatf("v%0d.instPc", i), instPc, tbl[i].pc);
    end
    rst = 1'b0; stall = 1'b0; jmpEn = 1'b0; jmpAddr = '0;

    // T4: 3-cycle memory, redirect in the 2nd wait cycle
    lat = 4'd2;
    step();                                   // IDLE -> FETCH
    chk("t4.ce_first", {31'd0, romCe}, 32'd1);
    step();                                   // 2nd wait cycle begins
    jmpEn = 1'b1; jmpAddr = 32'h103;
    step();
    jmpEn = 1'b0; jmpAddr = '0;
    chk("t4.sq_ce",   {31'd0, romCe},     32'd1);
    chk("t4.sq_addr", romAddr,            32'h0);
    chk("t4.sq_vld",  {31'd0, instValid}, 32'd0);
    step();                                   // old data returns and is dropped
    chk("t4.new_addr", romAddr,            32'h100);
    chk("t4.drop_vld", {31'd0, instValid}, 32'd0);
    wait_valid("t4.first", 32'h100);

    // T6a: PC wrap
    lat = 4'd0;
    jmpEn = 1'b1; jmpAddr = 32'hFFFF_FFFC;
    step();
    jmpEn = 1'b0; jmpAddr = '0;
    chk("t6.top_addr", romAddr, 32'hFFFF_FFFC);
    step();
    chk("t6.wrap_addr", romAddr, 32'h0);
    chk("t6.top_pc",    instPc,  32'hFFFF_FFFC);
    chk("t6.top_inst",  inst,    32'hFFFF_FFFC ^ XK);
    step();
    chk("t6.zero_pc",   instPc,  32'h0);
    chk("t6.zero_vld",  {31'd0, instValid}, 32'd1);

    // T6b: reset during SQUASH, late romRdy ignored
    lat = 4'd2;
    jmpEn = 1'b1; jmpAddr = 32'h600;
    step();
    jmpEn = 1'b0; jmpAddr = '0;
    chk("t6.sq_ce",   {31'd0, romCe}, 32'd1);
    chk("t6.sq_addr", romAddr,        32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("t6.rst_sq");
    frc = 1'b1; f_rdy = 1'b1;                 // stray response while idle
    step();
    frc = 1'b0; f_rdy = 1'b0;
    chk("t6.post_ce",   {31'd0, romCe},     32'd1);
    chk("t6.post_addr", romAddr,            32'h0);
    chk("t6.post_vld",  {31'd0, instValid}, 32'd0);
    wait_valid("t6.first", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
